hkspi_sysclk: RTL and testbench
===============================

HKSPI_SYSCLK -- requirements
Module: hkspi_sysclk

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address field width in bits, legal values 8/16/24.
REQ-002 SHALL have parameter DATA_W, default 8, data word width in bits, legal values 8/16/32.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth, legal range 2..4.
REQ-004 SHALL have port clk  in  1  system clock; the only clock in the block.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports spi_sck, spi_csb, spi_sdi  in  1 each  asynchronous SPI pins (mode 0, CSB active low).
REQ-007 SHALL have ports spi_sdo and spi_sdoenb  out  1 each  serial data out and its active-low output enable.
REQ-008 SHALL have port addr  out  ADDR_W  register address of the current word.
REQ-009 SHALL have port wdata  out  DATA_W  assembled write word.
REQ-010 SHALL have ports wr_strobe and rd_strobe  out  1 each  single-clk pulses.
REQ-011 SHALL have port rdata  in  DATA_W  read word for addr, sampled one clk after rd_strobe.
REQ-012 SHALL have ports pass_thru_mgmt, pass_thru_user, busy  out  1 each  pass-through flags and transaction-active flag.

Function
REQ-013 SHALL synchronise spi_sck, spi_csb, spi_sdi through SYNC_STAGES flops each, with reset values 0, 1, 0; all logic SHALL use only the synchronised copies.
REQ-014 SHALL detect SCK rise/fall as a 0->1 / 1->0 change between the last two synchroniser stages; legal input requires each SCK phase >= SYNC_STAGES+3 clk.
REQ-015 SHALL implement states IDLE, CMD, ADDR, DATA, PASS, DONE; synced CSB high forces IDLE on the next clk from any state.
REQ-016 IDLE->CMD SHALL occur on synced CSB low; busy SHALL be 1 in every state except IDLE.
REQ-017 SHALL sample SDI msb-first on SCK rise only; SHALL update spi_sdo on SCK fall only.
REQ-018 Command byte bits: [7] write, [6] read, [5:3] word count N (0 = unlimited), [2] mgmt pass, [1] user pass, [0] ignored.
REQ-019 After 8 command bits: exactly one of [2:1] set with [7:6]=11 -> PASS; all other values -> ADDR.
REQ-020 In PASS, pass_thru_mgmt or pass_thru_user SHALL be 1 from the clk after the 8th command bit until IDLE; spi_sdoenb SHALL be 0 and spi_sdo 0.
REQ-021 ADDR SHALL shift in ADDR_W bits into addr, then enter DATA.
REQ-022 If read set, rd_strobe SHALL pulse the clk after the last address bit and the clk after the last bit of each data word except the final word of a counted burst; the shift register SHALL load rdata the following clk.
REQ-023 In DATA with read set, spi_sdoenb SHALL be 0 and spi_sdo SHALL present the loaded word msb-first, first bit on the first SCK fall after load; otherwise spi_sdoenb SHALL be 1.
REQ-024 SHALL shift SDI into wdata; after each DATA_W bits with write set, wr_strobe SHALL pulse one clk with addr/wdata holding that word's address/data.
REQ-025 After each complete word, addr SHALL increment by 1, modulo 2^ADDR_W (all-ones wraps to 0), one clk after any wr_strobe.
REQ-026 With N != 0, after N complete words SHALL enter DONE: ignore SCK/SDI, no strobes, spi_sdoenb 1, until CSB high.
REQ-027 CSB high mid-word SHALL discard the partial word: no wr_strobe, no addr increment.
REQ-028 Command with [7:6]=00 SHALL shift address/data without any strobe or drive.

Reset
REQ-029 On reset SHALL force: state IDLE, spi_sdo 0, spi_sdoenb 1, addr 0, wdata 0, wr_strobe 0, rd_strobe 0, pass flags 0, busy 0, synchronisers to REQ-013 values.
REQ-030 Reset asserted mid-transaction SHALL take effect on the next clk; no strobe SHALL be emitted in that or the following clk.
REQ-031 After reset, a transaction SHALL start only on a CSB high->low transition seen after reset release.

Verification
REQ-032 Write N=1, ADDR_W=8: cmd 0x88, addr 0x10, data 0xA5 -> one wr_strobe, addr=0x10, wdata=0xA5; then DONE, no more strobes.
REQ-033 Read N=2: cmd 0x50, addr 0x20, rdata=addr+0x30 -> rd_strobes for 0x20,0x21; SDO 0x50 then 0x51; sdoenb 1 after.
REQ-034 Streaming write N=0 starting at addr 0xFE, 3 words -> wr_strobes at addr 0xFE, 0xFF, 0x00.
REQ-035 Cmd 0xC4 -> pass_thru_mgmt 1, sdoenb 0 until CSB high; cmd 0xC6 -> ADDR, no pass flag.
REQ-036 DATA_W=16, ADDR_W=16: CSB high after 11 data bits -> no wr_strobe, addr unchanged, busy 0 within SYNC_STAGES+2 clk.
REQ-037 Reset pulsed during DATA bit 4 -> all outputs at reset values next clk; a subsequent 0x88 transaction completes normally.

Source files
------------

// File: rtl/hkspi_sysclk.sv
`default_nettype none
// ============================================================================
// Module   : hkspi_sysclk
// Brief    : Housekeeping SPI slave (mode 0) fully sampled in the system
//            clock domain. Decodes a command byte, an address and a stream
//            of data words, and emits single-clk register read/write strobes.
// Revision : 1.0  initial release
// ============================================================================
module hkspi_sysclk #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdoenb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              wr_strobe,
  output logic              rd_strobe,
  input  logic [DATA_W-1:0] rdata,
  output logic              pass_thru_mgmt,
  output logic              pass_thru_user,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_PASS = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, csb_sync, sdi_sync;
  logic [SYNC_STAGES-1:0] fill;      // marks synchroniser contents as real samples
  logic                   armed;     // CSB seen high since reset release
  logic [7:0]             cmd_sr;
  logic [5:0]             bit_cnt;
  logic [2:0]             word_cnt;
  logic [DATA_W-1:0]      tx_sr;
  logic                   rd_load;   // rdata is valid: load it into tx_sr
  logic                   inc_pend;  // address increment deferred behind wr_strobe
  logic                   rd_pend;   // read strobe deferred until after that increment

  logic       sck_rise, sck_fall, csb_s, sdi_s;
  logic [7:0] cmd_next;
  logic       pass_sel, cmd_last, addr_last, data_last, last_word;
  logic [2:0] word_n;

  assign sck_rise  = sck_sync[SYNC_STAGES-2] & ~sck_sync[SYNC_STAGES-1];
  assign sck_fall  = ~sck_sync[SYNC_STAGES-2] & sck_sync[SYNC_STAGES-1];
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];

  assign cmd_next  = {cmd_sr[6:0], sdi_s};
  // Pass-through needs both R and W bits plus exactly one of the two pass bits
  assign pass_sel  = cmd_next[7] & cmd_next[6] & (cmd_next[2] ^ cmd_next[1]);
  assign word_n    = cmd_sr[5:3];
  assign cmd_last  = (bit_cnt == 6'd7);
  assign addr_last = (bit_cnt == 6'(ADDR_W - 1));
  assign data_last = (bit_cnt == 6'(DATA_W - 1));
  assign last_word = (word_n != 3'd0) && (word_cnt == word_n - 3'd1);

  assign busy           = (state != S_IDLE);
  assign pass_thru_mgmt = (state == S_PASS) & cmd_sr[2];
  assign pass_thru_user = (state == S_PASS) & cmd_sr[1];
  assign spi_sdoenb     = ~((state == S_PASS) | ((state == S_DATA) & cmd_sr[6]));

  // Input synchronisers; CSB idles high so its chain resets to ones
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= '0;
      csb_sync <= '1;
      sdi_sync <= '0;
      fill     <= '0;
      armed    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      if (fill[SYNC_STAGES-1] && csb_s) armed <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; a deasserted CSB overrides every state
  always_comb begin
    state_nxt = state;
    if (csb_s) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (armed) state_nxt = S_CMD;
        S_CMD:  if (sck_rise && cmd_last) state_nxt = pass_sel ? S_PASS : S_ADDR;
        S_ADDR: if (sck_rise && addr_last) state_nxt = S_DATA;
        S_DATA: if (sck_rise && data_last && last_word) state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Shift registers, counters, strobes and serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_sr    <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      addr      <= '0;
      wdata     <= '0;
      tx_sr     <= '0;
      spi_sdo   <= 1'b0;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      rd_load   <= 1'b0;
      inc_pend  <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      inc_pend  <= 1'b0;
      rd_pend   <= 1'b0;
      rd_load   <= rd_strobe;
      if (rd_load) tx_sr <= rdata;
      // Increment after a write strobe, then request the next read word
      if (inc_pend) begin
        addr      <= addr + ADDR_ONE;
        rd_strobe <= rd_pend;
      end
      if (csb_s || state == S_IDLE) begin
        cmd_sr   <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        spi_sdo  <= 1'b0;
      end else begin
        unique case (state)
          S_CMD: begin
            if (sck_rise) begin
              cmd_sr  <= cmd_next;
              bit_cnt <= cmd_last ? 6'd0 : bit_cnt + 6'd1;
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              addr <= {addr[ADDR_W-2:0], sdi_s};
              if (addr_last) begin
                bit_cnt   <= 6'd0;
                rd_strobe <= cmd_sr[6];
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          S_DATA: begin
            if (sck_rise) begin
              wdata <= {wdata[DATA_W-2:0], sdi_s};
              if (data_last) begin
                bit_cnt  <= 6'd0;
                word_cnt <= word_cnt + 3'd1;
                if (cmd_sr[7]) begin
                  wr_strobe <= 1'b1;
                  inc_pend  <= 1'b1;
                  rd_pend   <= cmd_sr[6] & ~last_word;
                end else begin
                  addr      <= addr + ADDR_ONE;
                  rd_strobe <= cmd_sr[6] & ~last_word;
                end
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
            if (sck_fall && cmd_sr[6]) begin
              spi_sdo <= tx_sr[DATA_W-1];
              tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hkspi_sysclk.sv
`default_nettype none
// ============================================================================
// Module   : tb_hkspi_sysclk
// Brief    : Self-checking bench for hkspi_sysclk: an SPI master task drives
//            transactions; expected strobes are queued and matched as they
//            appear on the register-side port.
// Revision : 1.0  initial release
// ============================================================================
module tb_hkspi_sysclk;

  localparam int HALF = 8;  // clk cycles per SCK phase

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0, sdi = 1'b0, csb8 = 1'b1, csb16 = 1'b1;

  logic        sdo8, sdoenb8, wr8, rd8, pm8, pu8, busy8;
  logic [7:0]  addr8, wdata8, rdata8;
  logic        sdo16, sdoenb16, wr16, rd16, pm16, pu16, busy16;
  logic [15:0] addr16, wdata16;
  logic [15:0] rdata16 = 16'h0000;

  int vectors = 0;
  int miscompares = 0;
  int strobe16_cnt = 0;
  logic enb_hi_seen;

  typedef struct { bit wr; logic [7:0] a; logic [7:0] d; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  assign rdata8 = addr8 + 8'h30;

  hkspi_sysclk #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .spi_sck(sck), .spi_csb(csb8), .spi_sdi(sdi),
    .spi_sdo(sdo8), .spi_sdoenb(sdoenb8), .addr(addr8), .wdata(wdata8),
    .wr_strobe(wr8), .rd_strobe(rd8), .rdata(rdata8),
    .pass_thru_mgmt(pm8), .pass_thru_user(pu8), .busy(busy8)
  );

  hkspi_sysclk #(.ADDR_W(16), .DATA_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .spi_sck(sck), .spi_csb(csb16), .spi_sdi(sdi),
    .spi_sdo(sdo16), .spi_sdoenb(sdoenb16), .addr(addr16), .wdata(wdata16),
    .wr_strobe(wr16), .rd_strobe(rd16), .rdata(rdata16),
    .pass_thru_mgmt(pm16), .pass_thru_user(pu16), .busy(busy16)
  );

  // Strobe monitor: every strobe must match the head of the expectation queue
  always @(negedge clk) begin
    if (wr8 || rd8) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected: got wr=%0b rd=%0b addr=%h wdata=%h, required no strobe",
                 wr8, rd8, addr8, wdata8);
      end else begin
        e = exp_q.pop_front();
        if (wr8 !== e.wr || rd8 !== !e.wr || addr8 !== e.a || (e.wr && wdata8 !== e.d)) begin
          miscompares++;
          $display("FAIL strobe: got wr=%0b rd=%0b addr=%h wdata=%h, required wr=%0b rd=%0b addr=%h wdata=%h",
                   wr8, rd8, addr8, wdata8, e.wr, !e.wr, e.a, e.d);
        end
      end
    end
    if (wr16 || rd16) strobe16_cnt++;
  end

  task automatic push_exp(input bit wr, input logic [7:0] a, input logic [7:0] d);
    exp_t x;
    x.wr = wr; x.a = a; x.d = d;
    exp_q.push_back(x);
  endtask

  task automatic cs_low(input bit sel16);
    @(negedge clk);
    if (sel16) csb16 = 1'b0; else csb8 = 1'b0;
  endtask

  task automatic cs_high(input bit sel16);
    repeat (HALF) @(negedge clk);
    if (sel16) csb16 = 1'b1; else csb8 = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic so);
    sdi = b;
    repeat (HALF) @(negedge clk);
    so = sdo8;
    if (sdoenb8) enb_hi_seen = 1'b1;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_xfer(input int n, input logic [31:0] v, output logic [31:0] rx);
    logic so;
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(v[i], so);
      rx = {rx[30:0], so};
    end
  endtask

  task automatic check_queue_empty(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected strobes never seen, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sdo8, sdoenb8, wr8, rd8, pm8, pu8, busy8} !== 7'b0100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required %b", {sdo8, sdoenb8, wr8, rd8, pm8, pu8, busy8}, 7'b0100000);
    end
    vectors++;
    if ({addr8, wdata8} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_addr_wdata: got %h, required 0000", {addr8, wdata8});
    end
    vectors++;
    if ({addr16, wdata16, busy16, sdoenb16} !== {32'h0, 2'b01}) begin
      miscompares++;
      $display("FAIL reset_dut16: got %h, required %h", {addr16, wdata16, busy16, sdoenb16}, {32'h0, 2'b01});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy got %b, required 0", busy8);
    end
  endtask

  task automatic test_write_n1();
    logic [31:0] rx;
    push_exp(1'b1, 8'h10, 8'hA5);
    cs_low(1'b0);
    spi_xfer(8, 32'h88, rx);
    spi_xfer(8, 32'h10, rx);
    spi_xfer(8, 32'hA5, rx);
    repeat (4) @(negedge clk);
    vectors++;
    if ({busy8, sdoenb8} !== 2'b11) begin
      miscompares++;
      $display("FAIL write_done_state: busy,sdoenb got %b, required 11", {busy8, sdoenb8});
    end
    spi_xfer(8, 32'h5A, rx);  // clocked while in DONE, must be ignored
    vectors++;
    if (wdata8 !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_done_ignores_sdi: wdata got %h, required a5", wdata8);
    end
    cs_high(1'b0);
    check_queue_empty("write_n1_strobes");
    vectors++;
    if ({addr8, busy8} !== {8'h11, 1'b0}) begin
      miscompares++;
      $display("FAIL write_addr_inc: addr,busy got %h,%b, required 11,0", addr8, busy8);
    end
  endtask

  task automatic test_read_n2();
    logic [31:0] rx;
    push_exp(1'b0, 8'h20, 8'h00);
    push_exp(1'b0, 8'h21, 8'h00);
    cs_low(1'b0);
    spi_xfer(8, 32'h50, rx);
    spi_xfer(8, 32'h20, rx);
    enb_hi_seen = 1'b0;
    spi_xfer(8, 32'h00, rx);
    vectors++;
    if (rx[7:0] !== 8'h50) begin
      miscompares++;
      $display("FAIL read_word0_sdo: got %h, required 50", rx[7:0]);
    end
    spi_xfer(8, 32'h00, rx);
    vectors++;
    if (rx[7:0] !== 8'h51) begin
      miscompares++;
      $display("FAIL read_word1_sdo: got %h, required 51", rx[7:0]);
    end
    vectors++;
    if (enb_hi_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL read_sdoenb_active: sdoenb high seen %b, required 0", enb_hi_seen);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (sdoenb8 !== 1'b1) begin
      miscompares++;
      $display("FAIL read_sdoenb_after: got %b, required 1", sdoenb8);
    end
    cs_high(1'b0);
    check_queue_empty("read_n2_strobes");
  endtask

  task automatic test_stream_wrap();
    logic [31:0] rx;
    push_exp(1'b1, 8'hFE, 8'h11);
    push_exp(1'b1, 8'hFF, 8'h22);
    push_exp(1'b1, 8'h00, 8'h33);
    cs_low(1'b0);
    spi_xfer(8, 32'h80, rx);
    spi_xfer(8, 32'hFE, rx);
    spi_xfer(8, 32'h11, rx);
    spi_xfer(8, 32'h22, rx);
    spi_xfer(8, 32'h33, rx);
    cs_high(1'b0);
    check_queue_empty("stream_strobes");
    vectors++;
    if (addr8 !== 8'h01) begin
      miscompares++;
      $display("FAIL stream_addr_wrap: got %h, required 01", addr8);
    end
  endtask

  task automatic test_pass_thru();
    logic [31:0] rx;
    cs_low(1'b0);
    spi_xfer(8, 32'hC4, rx);
    vectors++;
    if ({pm8, pu8, sdoenb8, sdo8, busy8} !== 5'b10001) begin
      miscompares++;
      $display("FAIL pass_mgmt: pm,pu,enb,sdo,busy got %b, required 10001", {pm8, pu8, sdoenb8, sdo8, busy8});
    end
    spi_xfer(8, 32'hFF, rx);
    vectors++;
    if ({pm8, pu8, sdoenb8, sdo8, busy8} !== 5'b10001) begin
      miscompares++;
      $display("FAIL pass_mgmt_hold: got %b, required 10001", {pm8, pu8, sdoenb8, sdo8, busy8});
    end
    cs_high(1'b0);
    vectors++;
    if ({pm8, pu8, sdoenb8, busy8} !== 4'b0010) begin
      miscompares++;
      $display("FAIL pass_release: got %b, required 0010", {pm8, pu8, sdoenb8, busy8});
    end
    cs_low(1'b0);
    spi_xfer(8, 32'hC2, rx);
    vectors++;
    if ({pm8, pu8, sdoenb8} !== 3'b010) begin
      miscompares++;
      $display("FAIL pass_user: pm,pu,enb got %b, required 010", {pm8, pu8, sdoenb8});
    end
    cs_high(1'b0);
    cs_low(1'b0);
    spi_xfer(8, 32'hC6, rx);
    repeat (4) @(negedge clk);
    vectors++;
    if ({pm8, pu8, sdoenb8, busy8} !== 4'b0011) begin
      miscompares++;
      $display("FAIL pass_both_bits: got %b, required 0011", {pm8, pu8, sdoenb8, busy8});
    end
    cs_high(1'b0);
  endtask

  task automatic test_partial_word16();
    logic [31:0] rx;
    cs_low(1'b1);
    spi_xfer(8, 32'h80, rx);
    spi_xfer(16, 32'h1234, rx);
    spi_xfer(11, 32'h5A5, rx);
    @(negedge clk);
    csb16 = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy16 !== 1'b0) begin
      miscompares++;
      $display("FAIL partial16_busy: got %b, required 0", busy16);
    end
    repeat (2*HALF) @(negedge clk);
    vectors++;
    if (addr16 !== 16'h1234) begin
      miscompares++;
      $display("FAIL partial16_addr: got %h, required 1234", addr16);
    end
    vectors++;
    if (strobe16_cnt !== 0) begin
      miscompares++;
      $display("FAIL partial16_strobe: got %0d strobes, required 0", strobe16_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rx;
    cs_low(1'b0);
    spi_xfer(8, 32'h88, rx);
    spi_xfer(8, 32'h40, rx);
    spi_xfer(4, 32'hA, rx);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({addr8, wdata8, sdo8, sdoenb8, wr8, rd8, pm8, pu8, busy8} !== {16'h0000, 7'b0100000}) begin
      miscompares++;
      $display("FAIL reset_mid: got %h, required %h",
               {addr8, wdata8, sdo8, sdoenb8, wr8, rd8, pm8, pu8, busy8}, {16'h0000, 7'b0100000});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wr8, rd8} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid_strobe: got %b, required 00", {wr8, rd8});
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_needs_csb_edge: busy got %b, required 0", busy8);
    end
    cs_high(1'b0);
    push_exp(1'b1, 8'h33, 8'h3C);
    cs_low(1'b0);
    spi_xfer(8, 32'h88, rx);
    spi_xfer(8, 32'h33, rx);
    spi_xfer(8, 32'h3C, rx);
    repeat (6) @(negedge clk);
    check_queue_empty("reset_mid_followup");
    vectors++;
    if ({wdata8, busy8} !== {8'h3C, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid_followup_state: wdata,busy got %h,%b, required 3c,1", wdata8, busy8);
    end
    cs_high(1'b0);
  endtask

  initial begin
    test_reset();
    test_write_n1();
    test_read_n2();
    test_stream_wrap();
    test_pass_thru();
    test_partial_word16();
    test_reset_mid();
    check_queue_empty("final_queue");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL timeout: simulation did not complete, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
